// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
//   state_t : controller FSM encoding. 2'd3 is unused and recovers to IDLE.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : sub_pkg

// File: rtl/fs_cell.sv
// 1-bit combinational full subtractor: computes a - b - bin.
// Ports:
//   a    in  minuend bit
//   b    in  subtrahend bit
//   bin  in  borrow in
//   d    out difference bit
//   bout out borrow out (1 when a < b + bin)
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_axb;

  // Difference and borrow of a single subtract stage
  always_comb begin
    w_axb = a ^ b;
    d     = w_axb ^ bin;
    bout  = (~a & b) | (~w_axb & bin);
  end

endmodule : fs_cell

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: diff = (a - b - bin) mod 2^WIDTH, LSB first,
// one bit per clock through a single shared fs_cell.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   request, accepted only in IDLE
//   a, b   in   operands (WIDTH), sampled on the accepting edge only
//   bin    in   borrow in, sampled on the accepting edge only
//   busy   out  high in RUN and DONE
//   done   out  one-cycle pulse; diff/bout valid from this cycle
//   diff   out  result (WIDTH), held until the next DONE transition
//   bout   out  final borrow (1 = unsigned underflow)
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  import sub_pkg::*;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  // r_a_sr doubles as the result shift register: minuend bits leave at the
  // bottom while difference bits enter at the top, so after the last bit
  // the register plus the final difference bit forms the whole result.
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic             r_brw;
  logic [CNT_W-1:0] r_cnt;
  logic             w_d;
  logic             w_brw_next;
  logic [WIDTH-1:0] w_res_next;

  fs_cell u_fs_cell (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .bin  (r_brw),
    .d    (w_d),
    .bout (w_brw_next)
  );

  // Result register contents after the current bit is shifted in
  always_comb begin
    w_res_next = {w_d, r_a_sr[WIDTH-1:1]};
  end

  // Controller FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_brw   <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_brw   <= bin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end else begin
            busy    <= 1'b0;
          end
        end
        RUN: begin
          r_a_sr <= w_res_next;
          r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_brw  <= w_brw_next;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BIT) begin
            diff    <= w_res_next;
            bout    <= w_brw_next;
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            done    <= 1'b0;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : serial_subtractor_ctrl

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl (WIDTH=8).
// Reference: {bout,diff} = {1'b0,a} - {1'b0,b} - bin in WIDTH+1 bit arithmetic.
module tb_serial_subtractor_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  int checks = 0;
  int errors = 0;

  serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] ma,
                                           input logic [WIDTH-1:0] mb,
                                           input logic mbin);
    logic [WIDTH:0] r;
    r = {1'b0, ma} - {1'b0, mb} - {{WIDTH{1'b0}}, mbin};
    return r;
  endfunction

  // Issues one request from IDLE and observes WIDTH+4 cycles after the accept edge.
  // lat is the number of edges after the accept edge before done is seen.
  task automatic op(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                    input logic bini, input bit scramble, input bit hold,
                    output int lat, output int ndone, output bit early,
                    output bit busy_run_ok, output bit busy_idle,
                    output bit busy_restart);
    logic [WIDTH-1:0] prev;
    @(posedge clk); #1;
    start = 1'b1; a = ai; b = bi; bin = bini;
    @(posedge clk); #1;
    start = hold;
    if (scramble) begin a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom); end
    prev = diff;
    lat = 0; ndone = 0; early = 1'b0; busy_run_ok = 1'b1;
    busy_idle = 1'b0; busy_restart = 1'b0;
    for (int i = 1; i <= WIDTH + 4; i++) begin
      @(posedge clk); #1;
      if (scramble) begin a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom); end
      if (done) begin
        ndone++;
        if (lat == 0) lat = i;
      end else if (lat == 0 && diff !== prev) begin
        early = 1'b1;
      end
      if (i <= WIDTH && !busy) busy_run_ok = 1'b0;
      if (i == WIDTH + 1) busy_idle = busy;
      if (i == WIDTH + 2) busy_restart = busy;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, diff, bout} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b diff=%h bout=%b, required all zero",
               busy, done, diff, bout);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, nd; bit early, bro, bi, br;
    logic [WIDTH:0] exp;
    op(8'h05, 8'h03, 1'b0, 1'b0, 1'b0, lat, nd, early, bro, bi, br);
    exp = model(8'h05, 8'h03, 1'b0);
    checks++;
    if (lat !== WIDTH) begin
      errors++; $display("FAIL basic_latency: got %0d edges, required %0d", lat, WIDTH);
    end
    checks++;
    if (nd !== 1) begin
      errors++; $display("FAIL basic_done_count: got %0d, required 1", nd);
    end
    checks++;
    if ({bout, diff} !== exp || exp !== 9'h002) begin
      errors++; $display("FAIL basic_result: got %b_%h, required %b_%h", bout, diff, exp[WIDTH], exp[WIDTH-1:0]);
    end
    checks++;
    if (!bro || bi !== 1'b0) begin
      errors++; $display("FAIL basic_busy: run_high=%b idle_busy=%b, required 1 0", bro, bi);
    end
  endtask

  task automatic test_underflow();
    int lat, nd; bit early, bro, bi, br;
    op(8'h03, 8'h05, 1'b0, 1'b0, 1'b0, lat, nd, early, bro, bi, br);
    checks++;
    if ({bout, diff} !== 9'h1FE) begin
      errors++; $display("FAIL underflow_3m5: got %b_%h, required 1_fe", bout, diff);
    end
    op(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, lat, nd, early, bro, bi, br);
    checks++;
    if ({bout, diff} !== 9'h1FF) begin
      errors++; $display("FAIL underflow_0m0m1: got %b_%h, required 1_ff", bout, diff);
    end
  endtask

  task automatic test_back_to_back();
    int lat, nd, waited; bit early, bro, bi, br;
    op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, lat, nd, early, bro, bi, br);
    checks++;
    if (nd !== 1 || lat !== WIDTH) begin
      errors++; $display("FAIL b2b_done: count=%0d lat=%0d, required 1 and %0d", nd, lat, WIDTH);
    end
    checks++;
    if ({bout, diff} !== 9'h0FE) begin
      errors++; $display("FAIL b2b_result: got %b_%h, required 0_fe", bout, diff);
    end
    checks++;
    if (bi !== 1'b0 || br !== 1'b1) begin
      errors++; $display("FAIL b2b_restart_from_idle: idle_busy=%b restart_busy=%b, required 0 1", bi, br);
    end
    // Let the restarted operation drain before the next scenario
    waited = 0;
    while (busy && waited < 40) begin
      @(posedge clk); #1; waited++;
    end
    checks++;
    if (busy) begin
      errors++; $display("FAIL b2b_drain_timeout: busy=%b after %0d cycles, required 0", busy, waited);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    @(posedge clk); #1;
    start = 1'b1; a = 8'h9C; b = 8'h21; bin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if ({busy, done, diff, bout} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b diff=%h bout=%b, required all zero", busy, done, diff, bout);
    end
    seen = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_no_done: %0d active cycles after reset, required 0", seen);
    end
  endtask

  task automatic test_scramble();
    int lat, nd; bit early, bro, bi, br;
    op(8'h5A, 8'h21, 1'b0, 1'b0, 1'b0, lat, nd, early, bro, bi, br);
    checks++;
    if ({bout, diff} !== 9'h039) begin
      errors++; $display("FAIL scramble_prior: got %b_%h, required 0_39", bout, diff);
    end
    op(8'hC3, 8'h3C, 1'b1, 1'b1, 1'b0, lat, nd, early, bro, bi, br);
    checks++;
    if (early !== 1'b0) begin
      errors++; $display("FAIL scramble_hold: diff changed before done=%b, required 0", early);
    end
    checks++;
    if ({bout, diff} !== 9'h086 || nd !== 1) begin
      errors++; $display("FAIL scramble_result: got %b_%h dones=%0d, required 0_86 dones=1", bout, diff, nd);
    end
  endtask

  task automatic test_random();
    int lat, nd, bad; bit early, bro, bi, br;
    logic [WIDTH-1:0] ra, rb; logic rbin;
    logic [WIDTH:0] exp;
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rbin = 1'($urandom);
      op(ra, rb, rbin, ($urandom_range(0, 3) == 0), 1'b0, lat, nd, early, bro, bi, br);
      exp = model(ra, rb, rbin);
      checks++;
      if ({bout, diff} !== exp || lat !== WIDTH || nd !== 1 || early) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_op: a=%h b=%h bin=%b got %b_%h lat=%0d dones=%0d early=%b, required %b_%h lat=%0d dones=1 early=0",
                   ra, rb, rbin, bout, diff, lat, nd, early, exp[WIDTH], exp[WIDTH-1:0], WIDTH);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_back_to_back();
    test_reset_mid_run();
    test_scramble();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_subtractor_ctrl
